// File: rtl/cordic_pkg.sv
// cordic_pkg
//   Shared definitions for the iterative CORDIC engine:
//   - cordic_state_e : controller states (IDLE, RUN, DONE)
//   - MODE_ROT/MODE_VEC : operating mode encodings
//   - ATAN_Q30 : atan(2^-i) for i = 0..31, rounded, in Q2.30
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cordic_state_e;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    // round(atan(2^-i) * 2^30). From i = 11 on the angle equals 2^-i to
    // within half an LSB, so the entries become exact powers of two.
    localparam logic [31:0] ATAN_Q30 [32] = '{
        32'h3243F6A9, 32'h1DAC6705, 32'h0FADBAFD, 32'h07F56EA7,
        32'h03FEAB77, 32'h01FFD55C, 32'h00FFFAAB, 32'h007FFF55,
        32'h003FFFEB, 32'h001FFFFD, 32'h00100000, 32'h00080000,
        32'h00040000, 32'h00020000, 32'h00010000, 32'h00008000,
        32'h00004000, 32'h00002000, 32'h00001000, 32'h00000800,
        32'h00000400, 32'h00000200, 32'h00000100, 32'h00000080,
        32'h00000040, 32'h00000020, 32'h00000010, 32'h00000008,
        32'h00000004, 32'h00000002, 32'h00000001, 32'h00000000
    };

endpackage

// File: rtl/cordic_atan_lut.sv
// cordic_atan_lut
//   Combinational arctangent table for the CORDIC micro-rotations.
//   Ports:
//     index [4:0]        - micro-rotation number i
//     angle [WIDTH-1:0]  - atan(2^-i) in Q2.(WIDTH-2)
//   Narrower widths are derived from the Q2.30 table by a rounding
//   right shift (add half an output LSB, then shift).
module cordic_atan_lut
    import cordic_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [4:0]       index,
    output logic [WIDTH-1:0] angle
);

    localparam int SHIFT = 32 - WIDTH;

    generate
        if (SHIFT == 0) begin : g_full
            assign angle = ATAN_Q30[index];
        end else begin : g_round
            // Largest entry is below 2^30, so the rounding add cannot carry out.
            logic [31:0] sum;
            logic        lut_unused;
            assign sum        = ATAN_Q30[index] + (32'd1 << (SHIFT - 1));
            assign angle      = sum[31:SHIFT];
            assign lut_unused = ^sum[SHIFT-1:0];
        end
    endgenerate

endmodule

// File: rtl/cordic_engine.sv
// cordic_engine
//   Iterative (one micro-rotation per clock) CORDIC in rotation or
//   vectoring mode. No gain compensation: x/y results carry gain K.
//   Ports:
//     clk, rst_n                 - clock, asynchronous active-low reset
//     mode                       - 0 rotation, 1 vectoring (sampled on accept)
//     x_in, y_in, z_in           - signed Q2.(WIDTH-2) operands
//     in_valid / in_ready        - operand handshake
//     x_out, y_out, z_out        - registered signed Q2.(WIDTH-2) results
//     out_valid / out_ready      - result handshake
//     busy                       - high while iterating
//     dbg_state_o                - current controller state
//
//   Handshakes: a transfer happens on a rising edge where valid and ready
//   are both high. in_ready is high only in IDLE, out_valid only in DONE;
//   x_out/y_out/z_out hold stable while out_valid waits for out_ready, and
//   the edge that releases DONE never also accepts new operands.
module cordic_engine
    import cordic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] z_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic [1:0]              dbg_state_o
);

    localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

    cordic_state_e state_q, state_d;
    logic [4:0]    i_q, i_d;
    logic          mode_q, mode_d;
    logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [WIDTH-1:0] xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;

    logic accept;
    logic last_iter;
    logic d_pos;
    logic signed [WIDTH-1:0] x_sh, y_sh, atan_w;
    logic signed [WIDTH-1:0] x_step, y_step, z_step;

    assign accept    = in_valid && (state_q == IDLE);
    assign last_iter = (i_q == LAST_ITER);

    cordic_atan_lut #(.WIDTH(WIDTH)) u_atan (
        .index (i_q),
        .angle (atan_w)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_iter) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready    = (state_q == IDLE);
        busy        = (state_q == RUN);
        out_valid   = (state_q == DONE);
        dbg_state_o = state_q;
    end

    // ---------------- shared micro-rotation datapath ----------------
    // d_pos means d = +1. Rotation drives z toward 0, vectoring drives y
    // toward 0; one add/sub per coordinate serves every iteration.
    always_comb begin
        x_sh = x_q >>> i_q;
        y_sh = y_q >>> i_q;
        if (mode_q == MODE_ROT) begin
            d_pos = ~z_q[WIDTH-1];
        end else begin
            d_pos = y_q[WIDTH-1];
        end
        x_step = d_pos ? (x_q - y_sh)   : (x_q + y_sh);
        y_step = d_pos ? (y_q + x_sh)   : (y_q - x_sh);
        z_step = d_pos ? (z_q - atan_w) : (z_q + atan_w);
    end

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        z_d    = z_q;
        i_d    = i_q;
        mode_d = mode_q;
        xo_d   = xo_q;
        yo_d   = yo_q;
        zo_d   = zo_q;
        if (accept) begin
            x_d    = x_in;
            y_d    = y_in;
            z_d    = z_in;
            mode_d = mode;
            i_d    = '0;
        end else if (state_q == RUN) begin
            x_d = x_step;
            y_d = y_step;
            z_d = z_step;
            i_d = i_q + 5'd1;
            // The final micro-rotation goes straight into the result registers.
            if (last_iter) begin
                xo_d = x_step;
                yo_d = y_step;
                zo_d = z_step;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            i_q    <= '0;
            mode_q <= MODE_ROT;
            xo_q   <= '0;
            yo_q   <= '0;
            zo_q   <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            z_q    <= z_d;
            i_q    <= i_d;
            mode_q <= mode_d;
            xo_q   <= xo_d;
            yo_q   <= yo_d;
            zo_q   <= zo_d;
        end
    end

    assign x_out = xo_q;
    assign y_out = yo_q;
    assign z_out = zo_q;

endmodule

// File: tb/tb_cordic_engine.sv
module tb_cordic_engine;
    import cordic_pkg::*;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [15:0] tx;
        logic [15:0] ty;
        logic [15:0] tz;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- DUT 0: WIDTH=32, ITER=24 ----------------
    logic        mode = 1'b0;
    logic [31:0] x_in = '0, y_in = '0, z_in = '0;
    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, busy;
    logic [31:0] x_out, y_out, z_out;
    logic [1:0]  dbg_state;

    cordic_engine #(.WIDTH(32), .ITER(24)) u_dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_out(x_out), .y_out(y_out), .z_out(z_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .dbg_state_o(dbg_state)
    );

    // ---------------- DUT 1: WIDTH=32, ITER=2 (exact, hand-traceable) ----------------
    logic        mode2 = 1'b0;
    logic [31:0] x_in2 = '0, y_in2 = '0, z_in2 = '0;
    logic        in_valid2 = 1'b0, out_ready2 = 1'b1;
    logic        in_ready2, out_valid2, busy2;
    logic [31:0] x_out2, y_out2, z_out2;
    logic [1:0]  dbg_state2;

    cordic_engine #(.WIDTH(32), .ITER(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .mode(mode2),
        .x_in(x_in2), .y_in(y_in2), .z_in(z_in2),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .x_out(x_out2), .y_out(y_out2), .z_out(z_out2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .busy(busy2), .dbg_state_o(dbg_state2)
    );

    // ---------------- scoreboard ----------------
    exp_t exp_q[$];
    exp_t exp2_q[$];
    exp_t e0, e1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp, input int tol);
        longint diff;
        n_cmp++;
        diff = longint'($signed(act)) - longint'($signed(exp));
        if (diff < 0) diff = -diff;
        if (diff > longint'(tol)) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (tol %0d)", name, act, exp, tol);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic exp_t mk(input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] z, input int tx, input int ty, input int tz);
        exp_t e;
        e.x = x; e.y = y; e.z = z;
        e.tx = 16'(tx); e.ty = 16'(ty); e.tz = 16'(tz);
        return e;
    endfunction

    // Monitors: a result is consumed on any cycle with valid && ready.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                timeout("unexpected_result_dut0");
            end else begin
                e0 = exp_q.pop_front();
                check("x_out", x_out, e0.x, int'(e0.tx));
                check("y_out", y_out, e0.y, int'(e0.ty));
                check("z_out", z_out, e0.z, int'(e0.tz));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid2 && out_ready2) begin
            if (exp2_q.size() == 0) begin
                timeout("unexpected_result_dut2");
            end else begin
                e1 = exp2_q.pop_front();
                check("x_out2", x_out2, e1.x, int'(e1.tx));
                check("y_out2", y_out2, e1.y, int'(e1.ty));
                check("z_out2", z_out2, e1.z, int'(e1.tz));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called between edges; returns #1 after the accept edge.
    task automatic send(input logic m, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] z, input bit push, input exp_t e);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) timeout("send_wait_idle");
        mode = m; x_in = x; y_in = y; z_in = z;
        in_valid = 1'b1;
        if (push) exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Operand changes after accept must not matter.
        mode = 1'($urandom_range(0, 1));
        x_in = $urandom(); y_in = $urandom(); z_in = $urandom();
    endtask

    task automatic wait_done(input string name);
        int guard = 0;
        while (!out_valid && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!out_valid) timeout(name);
        while (out_valid && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (out_valid) timeout(name);
    endtask

    task automatic send2(input logic m, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] z, input exp_t e);
        int guard = 0;
        while (!in_ready2 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready2) timeout("send2_wait_idle");
        mode2 = m; x_in2 = x; y_in2 = y; z_in2 = z;
        in_valid2 = 1'b1;
        exp2_q.push_back(e);
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        x_in2 = $urandom(); y_in2 = $urandom(); z_in2 = $urandom();
    endtask

    // ---------------- stimulus ----------------
    localparam logic [31:0] INV_K   = 32'h26DD3B6A;
    localparam logic [31:0] PI_4    = 32'h3243F6A9;
    localparam logic [31:0] NPI_4   = 32'hCDBC0957;
    localparam logic [31:0] COS45   = 32'h2D413CCD;
    localparam logic [31:0] NCOS45  = 32'hD2BEC333;
    localparam logic [31:0] VEC_MAG = 32'd1250302932;  // K*sqrt(0.5)*2^30

    logic [31:0] cx, cy, cz;
    int          run_bad;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        // Reset state, checked while rst_n is still low.
        #12;
        check("rst_in_ready",  32'(in_ready),  32'd1, 0);
        check("rst_busy",      32'(busy),      32'd0, 0);
        check("rst_out_valid", 32'(out_valid), 32'd0, 0);
        check("rst_x_out",     x_out,          32'd0, 0);
        check("rst_z_out",     z_out,          32'd0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Exact two-iteration traces on the small instance.
        send2(MODE_ROT, 32'h10000000, 32'h00000000, 32'h00000000,
              mk(32'h18000000, 32'h08000000, 32'hEB68705C, 0, 0, 0));
        send2(MODE_VEC, 32'h20000000, 32'h10000000, 32'h00000000,
              mk(32'h38000000, 32'h08000000, 32'h14978FA4, 0, 0, 0));

        // Latency and handshake during RUN, rotation by +pi/4.
        send(MODE_ROT, INV_K, 32'd0, PI_4, 1'b1, mk(COS45, COS45, 32'd0, 128, 128, 128));
        run_bad = 0;
        for (int k = 1; k <= 23; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) run_bad++;
            in_valid = (k == 5 || k == 6 || k == 15);
        end
        in_valid = 1'b0;
        check("run_flags_bad_cycles", 32'(run_bad), 32'd0, 0);
        @(posedge clk); #1;
        check("latency_out_valid", 32'(out_valid), 32'd1, 0);
        check("done_busy",         32'(busy),      32'd0, 0);
        wait_done("latency_result");

        // Vectoring of (0.5, 0.5).
        send(MODE_VEC, 32'h20000000, 32'h20000000, 32'd0, 1'b1,
             mk(VEC_MAG, 32'd0, PI_4, 256, 128, 128));
        wait_done("vectoring_result");

        // Rotation by -pi/4.
        send(MODE_ROT, INV_K, 32'd0, NPI_4, 1'b1, mk(COS45, NCOS45, 32'd0, 128, 128, 128));
        wait_done("neg_angle_result");

        // Backpressure: hold DONE for 10 cycles with in_valid asserted.
        out_ready = 1'b0;
        send(MODE_ROT, INV_K, 32'd0, PI_4, 1'b1, mk(COS45, COS45, 32'd0, 128, 128, 128));
        begin
            int guard = 0;
            while (!out_valid && guard < 100) begin
                @(posedge clk); #1;
                guard++;
            end
            if (!out_valid) timeout("bp_wait_done");
        end
        cx = x_out; cy = y_out; cz = z_out;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 32'd1, 0);
            check("bp_in_ready",  32'(in_ready),  32'd0, 0);
            check("bp_x_hold",    x_out, cx, 0);
            check("bp_y_hold",    y_out, cy, 0);
            check("bp_z_hold",    z_out, cz, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready",  32'(in_ready),  32'd1, 0);
        check("bp_release_busy",      32'(busy),      32'd0, 0);
        check("bp_release_out_valid", 32'(out_valid), 32'd0, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Reset during iteration 7: no result, everything cleared at once.
        send(MODE_VEC, 32'h20000000, 32'h20000000, 32'd0, 1'b0, mk(0, 0, 0, 0, 0, 0));
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0, 0);
        check("mid_rst_busy",      32'(busy),      32'd0, 0);
        check("mid_rst_in_ready",  32'(in_ready),  32'd1, 0);
        check("mid_rst_x_out",     x_out,          32'd0, 0);
        check("mid_rst_y_out",     y_out,          32'd0, 0);
        check("mid_rst_z_out",     z_out,          32'd0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle_out_valid", 32'(out_valid), 32'd0, 0);
        send(MODE_ROT, INV_K, 32'd0, NPI_4, 1'b1, mk(COS45, NCOS45, 32'd0, 128, 128, 128));
        wait_done("post_reset_result");

        repeat (5) @(posedge clk);
        #1;
        check("dut0_queue_empty", 32'(exp_q.size()),  32'd0, 0);
        check("dut2_queue_empty", 32'(exp2_q.size()), 32'd0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
